// File: rtl/up_down_counter.sv
// up_down_counter
//   Free-running WIDTH-bit binary up/down counter. Counts by exactly one on
//   every rising clk edge and wraps modulo 2^WIDTH in both directions.
//   Terminal-count decodes and an optional registered wrap pulse let
//   sequencing logic detect boundary crossings without decoding count.
//
// Build option:
//   UP_DOWN_COUNTER_WRAP_PULSE_EN  defined   -> wrap pulses for one cycle
//                                              after each up- or down-wrap
//                                  undefined -> wrap tied to 0, no register
//
// Parameters:
//   WIDTH    counter width in bits (>= 2), default 8
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high clear (priority over counting)
//   up_down  direction select, 1 = increment, 0 = decrement
//   count    registered counter value
//   at_max   combinational, count == all ones
//   at_min   combinational, count == 0
//   wrap     registered one-cycle wrap pulse (0 when the build option is off)

module up_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             is_max;
  logic             is_min;

  assign is_max = (count_q == CNT_MAX);
  assign is_min = (count_q == CNT_ZERO);

  // Carry/borrow is simply dropped, which gives the modulo wrap for free.
  always_comb begin
    count_d = count_q;
    if (up_down) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef UP_DOWN_COUNTER_WRAP_PULSE_EN
  logic wrap_q;
  logic wrap_d;

  // A wrap happens on this edge when we sit at the boundary we are heading
  // towards; registering it aligns the pulse with the wrapped count value.
  always_comb begin
    wrap_d = 1'b0;
    if (up_down) begin
      wrap_d = is_max;
    end else begin
      wrap_d = is_min;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

  assign count  = count_q;
  assign at_max = is_max;
  assign at_min = is_min;

endmodule

// File: tb/tb_up_down_counter.sv
module tb_up_down_counter;

  logic       clk;
  logic       rst;
  logic       up_down;
  logic       up_down4;
  logic [7:0] count;
  logic       at_max;
  logic       at_min;
  logic       wrap;
  logic [3:0] count4;
  logic       at_max4;
  logic       at_min4;
  logic       wrap4;

  int n_checks = 0;
  int n_errors = 0;

`ifdef UP_DOWN_COUNTER_WRAP_PULSE_EN
  localparam logic WRAP_ON = 1'b1;
`else
  localparam logic WRAP_ON = 1'b0;
`endif

  up_down_counter #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .up_down (up_down),
    .count   (count),
    .at_max  (at_max),
    .at_min  (at_min),
    .wrap    (wrap)
  );

  up_down_counter #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .up_down (up_down4),
    .count   (count4),
    .at_max  (at_max4),
    .at_min  (at_min4),
    .wrap    (wrap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle before sampling / changing inputs
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] c, input logic mx,
                      input logic mn, input logic w);
    chk({tag, ".count"},  {24'd0, count}, {24'd0, c});
    chk({tag, ".at_max"}, {31'd0, at_max}, {31'd0, mx});
    chk({tag, ".at_min"}, {31'd0, at_min}, {31'd0, mn});
    chk({tag, ".wrap"},   {31'd0, wrap},   {31'd0, w});
  endtask

  initial begin
    rst      = 1'b1;
    up_down  = 1'b1;
    up_down4 = 1'b0;

    // reset held for two edges with up_down toggling
    step();
    chk8("rst_e1", 8'h00, 1'b0, 1'b1, 1'b0);
    up_down = 1'b0;
    step();
    chk8("rst_e2", 8'h00, 1'b0, 1'b1, 1'b0);
    chk("w4_rst", {28'd0, count4}, 32'h0);

    // count up two edges; WIDTH=4 instance counts down from 0
    rst     = 1'b0;
    up_down = 1'b1;
    step();
    chk8("up_1", 8'h01, 1'b0, 1'b0, 1'b0);
    chk("w4_down_wrap.count",  {28'd0, count4}, 32'hF);
    chk("w4_down_wrap.at_max", {31'd0, at_max4}, 32'd1);
    chk("w4_down_wrap.at_min", {31'd0, at_min4}, 32'd0);
    chk("w4_down_wrap.wrap",   {31'd0, wrap4},   {31'd0, WRAP_ON});
    step();
    chk8("up_2", 8'h02, 1'b0, 1'b0, 1'b0);
    chk("w4_down2.count", {28'd0, count4}, 32'hE);
    chk("w4_down2.wrap",  {31'd0, wrap4},  32'd0);

    // count down to zero, then down-wrap
    up_down = 1'b0;
    step();
    chk8("dn_1", 8'h01, 1'b0, 1'b0, 1'b0);
    step();
    chk8("dn_0", 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    chk8("dn_wrap", 8'hFF, 1'b1, 1'b0, WRAP_ON);

    // up-wrap straight after, then pulse must drop
    up_down = 1'b1;
    step();
    chk8("up_wrap", 8'h00, 1'b0, 1'b1, WRAP_ON);
    step();
    chk8("post_wrap", 8'h01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk8("up_5", 8'h05, 1'b0, 1'b0, 1'b0);

    // mid-count reset, held two edges, resume counting up
    rst = 1'b1;
    step();
    chk8("mid_rst1", 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    chk8("mid_rst2", 8'h00, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    chk8("resume_up", 8'h01, 1'b0, 1'b0, 1'b0);
    step();
    chk8("resume_up2", 8'h02, 1'b0, 1'b0, 1'b0);

    // release reset with up_down=0 -> immediate down-wrap
    rst = 1'b1;
    step();
    chk8("rst_again", 8'h00, 1'b0, 1'b1, 1'b0);
    rst     = 1'b0;
    up_down = 1'b0;
    step();
    chk8("rel_dn_wrap", 8'hFF, 1'b1, 1'b0, WRAP_ON);
    step();
    chk8("rel_dn_next", 8'hFE, 1'b0, 1'b0, 1'b0);

    // direction change takes effect on the very next edge
    up_down = 1'b1;
    step();
    chk8("dir_flip", 8'hFF, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
